strobe_gen: RTL

STROBE_GEN -- requirements
Module: strobe_gen

---
 rtl/strobe_gen_pkg.sv | 12 +
 rtl/sat_updown_cnt.sv | 41 ++++
 rtl/strobe_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/strobe_gen_pkg.sv
// Shared definitions for the strobe generator: FSM state encoding and timer width.
package strobe_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_e;

  localparam int TIMER_W = 8;

endpackage

// File: rtl/sat_updown_cnt.sv
// Saturating up/down counter holding the number of pending strobe requests.
// An increment that arrives while full without a same-cycle decrement is
// refused and reported on drop_o.
module sat_updown_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o,
  output logic         drop_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         full;

  // Full detection and drop reporting.
  always_comb begin
    full   = (cnt_q == {W{1'b1}});
    drop_o = inc_i && !dec_i && full;
  end

  // Next count: inc and dec together cancel; otherwise saturate at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full)
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/strobe_gen.sv
// Strobe generator: turns single-cycle trigger requests into fixed-width
// pulses with a guaranteed low gap, queueing requests that arrive while busy.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no pulse in progress, waiting for a request
// HIGH    | strobe_out high, timer counts down the high time
// LOW     | strobe_out low, timer counts down the minimum gap
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int HIGH_CYCLES = 2,
  parameter int LOW_CYCLES  = 2,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trig,
  input  logic              clr_ovf,
  output logic              strobe_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam logic [TIMER_W-1:0] HIGH_LOAD = TIMER_W'(HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOW_LOAD  = TIMER_W'(LOW_CYCLES - 1);

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               strobe_q, strobe_d;
  logic               ovf_q, ovf_d;
  logic               pend_nz, req_avail, start;
  logic               use_pend, use_trig, cnt_inc, cnt_drop;

  // State, timer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next state and timer; start marks every entry into HIGH.
  always_comb begin
    pend_nz   = (pend_cnt != '0);
    req_avail = pend_nz || trig;
    state_d   = state_q;
    timer_d   = timer_q;
    start     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_avail) begin
          state_d = ST_HIGH;
          timer_d = HIGH_LOAD;
          start   = 1'b1;
        end
      end
      ST_HIGH: begin
        if (timer_q == '0) begin
          state_d = ST_LOW;
          timer_d = LOW_LOAD;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_LOW: begin
        if (timer_q == '0) begin
          if (req_avail) begin
            state_d = ST_HIGH;
            timer_d = HIGH_LOAD;
            start   = 1'b1;
          end else begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // Request bookkeeping and output decode. Pending requests are served
  // before a same-cycle trig; a trig that starts a pulse directly never
  // touches the pending counter.
  always_comb begin
    use_pend = start && pend_nz;
    use_trig = start && !pend_nz && trig;
    cnt_inc  = trig && !use_trig;
    strobe_d = (state_d == ST_HIGH);
    ovf_d    = cnt_drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    busy     = (state_q != ST_IDLE);
  end

  sat_updown_cnt #(
    .W(PEND_W)
  ) u_pend_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc_i (cnt_inc),
    .dec_i (use_pend),
    .cnt_o (pend_cnt),
    .drop_o(cnt_drop)
  );

  assign strobe_out = strobe_q;
  assign overflow   = ovf_q;

endmodule
